// File: rtl/aer_event_sender.sv
// Event FIFO feeding a 4-phase REQ/ACK AER link, with encoder back-pressure,
// link status and a wrapping count of completed handshakes.
module aer_event_sender #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_BITS  = 10,
    parameter int CNT_BITS   = 16
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic [ADDR_BITS-1:0] NEXT_INDEX,
    input  logic                 FOUND_NEXT_INDEX,
    input  logic                 FLUSH,
    output logic                 AERIN_CTRL_BUSY,
    output logic [ADDR_BITS-1:0] AEROUT_ADDR,
    output logic                 AEROUT_REQ,
    input  logic                 AEROUT_ACK,
    output logic                 LINK_IDLE,
    output logic                 OVERFLOW,
    output logic [CNT_BITS-1:0]  EVENTS_SENT
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] BUSY_CNT = (PTR_W+1)'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_ACK_LOW
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       count_q, count_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 req_q, req_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_BITS-1:0]  sent_q, sent_d;
    logic                 ack_meta_q, ack_s_q;
    logic [ADDR_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [ADDR_BITS-1:0] mem_d [FIFO_DEPTH];
    logic                 pop, push_ok, drop;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        req_d    = req_q;
        sent_d   = sent_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        pop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    addr_d  = mem_q[rd_ptr_q];
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_s_q) begin
                    req_d   = 1'b0;
                    sent_d  = sent_q + CNT_BITS'(1);
                    state_d = S_WAIT_ACK_LOW;
                end
            end
            S_WAIT_ACK_LOW: begin
                if (!ack_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A pop in the same cycle frees the slot, so a push at full still lands.
        push_ok = FOUND_NEXT_INDEX && !FLUSH && ((count_q != FULL_CNT) || pop);
        drop    = FOUND_NEXT_INDEX && !FLUSH && (count_q == FULL_CNT) && !pop;

        if (FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop)      count_d = count_q + (PTR_W+1)'(1);
            else if (pop && !push_ok) count_d = count_q - (PTR_W+1)'(1);
            if (drop) ovf_d = 1'b1;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = NEXT_INDEX;
    end

    // Storage carries data only and needs no reset.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            req_q      <= 1'b0;
            ovf_q      <= 1'b0;
            sent_q     <= '0;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            ovf_q      <= ovf_d;
            sent_q     <= sent_d;
            ack_meta_q <= AEROUT_ACK;
            ack_s_q    <= ack_meta_q;
        end
    end

    assign AERIN_CTRL_BUSY = (count_q >= BUSY_CNT);
    assign AEROUT_ADDR     = addr_q;
    assign AEROUT_REQ      = req_q;
    assign LINK_IDLE       = (count_q == '0) && (state_q == S_IDLE);
    assign OVERFLOW        = ovf_q;
    assign EVENTS_SENT     = sent_q;

endmodule

// File: tb/tb_aer_event_sender.sv
// Directed bench for aer_event_sender: reset, single event, back-pressure,
// overflow/flush, push+pop at full, random stress and reset mid-handshake.
module tb_aer_event_sender;

    localparam int DEPTH = 4;
    localparam int AW    = 10;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] next_index;
    logic          found;
    logic          flush;
    logic          busy;
    logic [AW-1:0] aer_addr;
    logic          aer_req;
    logic          aer_ack;
    logic          link_idle;
    logic          overflow;
    logic [CW-1:0] events_sent;

    int n_vec = 0;
    int n_err = 0;
    logic [AW-1:0] exp_q[$];

    aer_event_sender #(
        .FIFO_DEPTH(DEPTH),
        .ADDR_BITS (AW),
        .CNT_BITS  (CW)
    ) dut (
        .CLK             (clk),
        .RSTN            (rst_n),
        .NEXT_INDEX      (next_index),
        .FOUND_NEXT_INDEX(found),
        .FLUSH           (flush),
        .AERIN_CTRL_BUSY (busy),
        .AEROUT_ADDR     (aer_addr),
        .AEROUT_REQ      (aer_req),
        .AEROUT_ACK      (aer_ack),
        .LINK_IDLE       (link_idle),
        .OVERFLOW        (overflow),
        .EVENTS_SENT     (events_sent)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Link responder: serves n handshakes, checking order, address stability and 4-phase ordering.
    task automatic serve(input int n, input int d_rise, input int d_fall, input bit rnd);
        for (int i = 0; i < n; i++) begin
            int cyc;
            int dr;
            int df;
            logic [AW-1:0] held;
            logic [AW-1:0] want;
            dr = rnd ? int'($urandom_range(0, 5)) : d_rise;
            df = rnd ? int'($urandom_range(0, 5)) : d_fall;
            cyc = 0;
            while (aer_req !== 1'b1 && cyc < 300) begin
                tick();
                cyc++;
            end
            chk("req_rise", 32'(aer_req), 32'h1);
            if (aer_req !== 1'b1) return;
            held = aer_addr;
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            chk("addr_order", 32'(held), 32'(want));
            repeat (dr) begin
                tick();
                chk("req_hold", 32'(aer_req), 32'h1);
                chk("addr_hold_req", 32'(aer_addr), 32'(held));
            end
            aer_ack = 1'b1;
            cyc = 0;
            while (aer_req !== 1'b0 && cyc < 50) begin
                tick();
                cyc++;
                chk("addr_hold_ack", 32'(aer_addr), 32'(held));
            end
            chk("req_fall", 32'(aer_req), 32'h0);
            repeat (df) begin
                tick();
                chk("addr_hold_acklo_wait", 32'(aer_addr), 32'(held));
                chk("req_low_ack_high", 32'(aer_req), 32'h0);
            end
            aer_ack = 1'b0;
            repeat (2) begin
                tick();
                chk("req_gap", 32'(aer_req), 32'h0);
            end
        end
    endtask

    task automatic pusher(input int n);
        for (int i = 0; i < n; i++) begin
            int cyc;
            logic [AW-1:0] a;
            repeat ($urandom_range(0, 2)) tick();
            cyc = 0;
            while (busy !== 1'b0 && cyc < 500) begin
                tick();
                cyc++;
            end
            chk("busy_release", 32'(busy), 32'h0);
            a = AW'($urandom_range(0, 1023));
            next_index = a;
            found = 1'b1;
            exp_q.push_back(a);
            tick();
            found = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        next_index = '0;
        found = 1'b0;
        flush = 1'b0;
        aer_ack = 1'b0;
        tick();
        tick();
        chk("rst_req", 32'(aer_req), 32'h0);
        chk("rst_addr", 32'(aer_addr), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_idle", 32'(link_idle), 32'h1);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_sent", 32'(events_sent), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single event
        next_index = 10'h1FF;
        found = 1'b1;
        tick();
        found = 1'b0;
        chk("se_req_k", 32'(aer_req), 32'h0);
        chk("se_idle_k", 32'(link_idle), 32'h0);
        tick();
        chk("se_req_k1", 32'(aer_req), 32'h1);
        chk("se_addr", 32'(aer_addr), 32'h1FF);
        tick();
        tick();
        aer_ack = 1'b1;
        tick();
        tick();
        chk("se_req_m1", 32'(aer_req), 32'h1);
        tick();
        chk("se_req_m2", 32'(aer_req), 32'h0);
        chk("se_sent", 32'(events_sent), 32'h1);
        tick();
        tick();
        aer_ack = 1'b0;
        tick();
        tick();
        chk("se_idle_n1", 32'(link_idle), 32'h0);
        tick();
        chk("se_idle_n2", 32'(link_idle), 32'h1);

        // Back-pressure
        for (int i = 1; i <= 4; i++) begin
            next_index = AW'(i);
            found = 1'b1;
            exp_q.push_back(AW'(i));
            tick();
            if (i == 3) chk("bp_busy_cnt2", 32'(busy), 32'h0);
            if (i == 4) chk("bp_busy_cnt3", 32'(busy), 32'h1);
        end
        found = 1'b0;
        chk("bp_req", 32'(aer_req), 32'h1);
        chk("bp_addr", 32'(aer_addr), 32'h001);
        chk("bp_ovf", 32'(overflow), 32'h0);
        serve(4, 1, 1, 1'b0);
        tick();
        chk("bp_idle", 32'(link_idle), 32'h1);
        chk("bp_sent", 32'(events_sent), 32'd5);
        chk("bp_ovf_end", 32'(overflow), 32'h0);

        // Overflow and flush
        for (int i = 0; i < 6; i++) begin
            next_index = AW'(10'h100 + i);
            found = 1'b1;
            tick();
            if (i == 4) chk("ov_ovf_full", 32'(overflow), 32'h0);
            if (i == 5) chk("ov_ovf_drop", 32'(overflow), 32'h1);
        end
        found = 1'b0;
        chk("ov_busy", 32'(busy), 32'h1);
        chk("ov_req", 32'(aer_req), 32'h1);
        chk("ov_addr", 32'(aer_addr), 32'h100);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_ovf", 32'(overflow), 32'h0);
        chk("fl_busy", 32'(busy), 32'h0);
        chk("fl_req", 32'(aer_req), 32'h1);
        chk("fl_addr", 32'(aer_addr), 32'h100);
        chk("fl_idle", 32'(link_idle), 32'h0);
        exp_q.push_back(10'h100);
        serve(1, 2, 0, 1'b0);
        tick();
        chk("fl_idle_end", 32'(link_idle), 32'h1);
        repeat (3) tick();
        chk("fl_no_more_req", 32'(aer_req), 32'h0);
        chk("fl_sent", 32'(events_sent), 32'd6);

        // Push and pop in the same cycle at full
        for (int i = 0; i < 5; i++) begin
            next_index = AW'(10'h200 + i);
            found = 1'b1;
            tick();
        end
        found = 1'b0;
        chk("pp_busy", 32'(busy), 32'h1);
        chk("pp_addr0", 32'(aer_addr), 32'h200);
        aer_ack = 1'b1;
        repeat (3) tick();
        chk("pp_req_fall", 32'(aer_req), 32'h0);
        aer_ack = 1'b0;
        repeat (3) tick();
        chk("pp_req_low", 32'(aer_req), 32'h0);
        chk("pp_not_idle", 32'(link_idle), 32'h0);
        next_index = 10'h205;
        found = 1'b1;
        tick();
        found = 1'b0;
        chk("pp_req", 32'(aer_req), 32'h1);
        chk("pp_addr1", 32'(aer_addr), 32'h201);
        chk("pp_ovf", 32'(overflow), 32'h0);
        chk("pp_busy_full", 32'(busy), 32'h1);
        for (int i = 1; i <= 5; i++) exp_q.push_back(AW'(10'h200 + i));
        serve(5, 0, 2, 1'b0);
        tick();
        chk("pp_idle", 32'(link_idle), 32'h1);
        chk("pp_sent", 32'(events_sent), 32'd12);

        // Random stress
        fork
            pusher(300);
            serve(300, 0, 0, 1'b1);
        join
        tick();
        chk("st_sent", 32'(events_sent), 32'd312);
        chk("st_idle", 32'(link_idle), 32'h1);
        chk("st_ovf", 32'(overflow), 32'h0);
        chk("st_queue_empty", 32'(exp_q.size()), 32'h0);

        // Reset in the middle of a request
        next_index = 10'h0AA;
        found = 1'b1;
        tick();
        found = 1'b0;
        tick();
        chk("mr_req_up", 32'(aer_req), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_req_async", 32'(aer_req), 32'h0);
        chk("mr_idle_async", 32'(link_idle), 32'h1);
        chk("mr_sent_async", 32'(events_sent), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("mr_req", 32'(aer_req), 32'h0);
        chk("mr_addr", 32'(aer_addr), 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_idle", 32'(link_idle), 32'h1);
        chk("mr_ovf", 32'(overflow), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
